// File: rtl/fe_capture_multi_if.sv
// fe_capture_multi_if
//   Record write stream between the multi-channel capture controller and
//   the capture FIFO.
//   master : fifo_wr, fifo_command, fifo_channel, fifo_time (out);
//            fifo_full, fifo_overflow_blocked (in)
//   slave  : the FIFO side, opposite directions.
//   Also provides the command code that marks TIME records.

`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

interface fe_capture_multi_if #(
  parameter int pCMD_WIDTH = 2,
  parameter int pCH_WIDTH  = 2,
  parameter int pTS_WIDTH  = 16
);
  logic                  fifo_wr;
  logic [pCMD_WIDTH-1:0] fifo_command;
  logic [pCH_WIDTH-1:0]  fifo_channel;
  logic [pTS_WIDTH-1:0]  fifo_time;
  logic                  fifo_full;
  logic                  fifo_overflow_blocked;

  modport master (
    output fifo_wr, fifo_command, fifo_channel, fifo_time,
    input  fifo_full, fifo_overflow_blocked
  );

  modport slave (
    input  fifo_wr, fifo_command, fifo_channel, fifo_time,
    output fifo_full, fifo_overflow_blocked
  );
endinterface

// File: rtl/fe_capture_multi.sv
// fe_capture_multi
//   Multi-channel front-end capture controller. Each channel owns a one-deep
//   event slot; occupied slots are drained round-robin into a single FIFO
//   record stream (TIME records for long gaps / keep-alive, DATA records
//   carrying channel + command). Counts dropped events, limits capture length.
//   Ports:
//     fe_clk, reset_n        clock, asynchronous active-low reset
//     I_event/I_data_cmd     per-channel event strobes and command codes
//     I_chan_enable          per-channel enable mask
//     I_arm, I_capture_*     arming, trigger gate, length limit
//     I_count_writes         length counts writes (1) or enabled cycles (0)
//     I_max_short_timestamp  largest delta carried inline in DATA
//     I_timestamps_disable   no TIME records, zero time field
//     fifo                   record stream + FIFO back-pressure (master)
//     O_capturing, O_capture_done, O_dropped_count, O_pending  status

module fe_capture_multi #(
  parameter int pCHANNELS  = 4,
  parameter int pCMD_WIDTH = 2,
  parameter int pTS_WIDTH  = 16,
  parameter int pLEN_WIDTH = 24
) (
  input  logic                            fe_clk,
  input  logic                            reset_n,
  input  logic [pCHANNELS-1:0]            I_event,
  input  logic [pCHANNELS*pCMD_WIDTH-1:0] I_data_cmd,
  input  logic [pCHANNELS-1:0]            I_chan_enable,
  input  logic                            I_arm,
  input  logic                            I_capture_enable,
  input  logic [pLEN_WIDTH-1:0]           I_capture_len,
  input  logic                            I_count_writes,
  input  logic [pTS_WIDTH-1:0]            I_max_short_timestamp,
  input  logic                            I_timestamps_disable,
  fe_capture_multi_if.master              fifo,
  output logic                            O_capturing,
  output logic                            O_capture_done,
  output logic [15:0]                     O_dropped_count,
  output logic [pCHANNELS-1:0]            O_pending
);
  localparam int pCH_WIDTH = $clog2(pCHANNELS);
  localparam logic [pCMD_WIDTH-1:0] TIME_CMD = pCMD_WIDTH'(`FE_FIFO_CMD_TIME);
  localparam logic [pTS_WIDTH-1:0]  TS_MAX   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_TIME, ST_DATA} state_t;
  state_t state_reg, state_next;

  logic                                  armed_reg, armed_next;
  logic [pLEN_WIDTH-1:0]                 count_reg, count_next;
  logic [15:0]                           dropped_reg, dropped_next;
  logic [pCHANNELS-1:0]                  pending_reg, pending_next;
  logic [pCHANNELS-1:0][pCMD_WIDTH-1:0]  cmd_reg, cmd_next;
  logic [pCH_WIDTH-1:0]                  rr_ptr_reg, rr_ptr_next;
  logic [pTS_WIDTH-1:0]                  ctr_reg, ctr_next;
  logic                                  wr_reg, wr_next;
  logic [pCMD_WIDTH-1:0]                 out_cmd_reg, out_cmd_next;
  logic [pCH_WIDTH-1:0]                  out_ch_reg, out_ch_next;
  logic [pTS_WIDTH-1:0]                  out_time_reg, out_time_next;
  logic                                  capturing_reg;

  logic                 capture_allowed;
  logic                 grant_valid;
  logic [pCH_WIDTH-1:0] grant_idx;
  logic [pCH_WIDTH-1:0] cand;
  logic                 serve;
  logic [pCHANNELS-1:0] fill, served, drop;
  logic [16:0]          drop_sum;

  assign capture_allowed = armed_reg & I_capture_enable & ~fifo.fifo_full &
                           ~fifo.fifo_overflow_blocked &
                           ((count_reg < I_capture_len) | (I_capture_len == '0));

  // Round-robin: rr_ptr_reg holds the first index to consider. Scanning
  // offsets from the far end down lets the nearest pending slot win.
  always_comb begin
    grant_valid = |pending_reg;
    grant_idx   = '0;
    cand        = '0;
    for (int off = pCHANNELS - 1; off >= 0; off--) begin
      cand = pCH_WIDTH'((int'(rr_ptr_reg) + off) % pCHANNELS);
      if (pending_reg[cand]) grant_idx = cand;
    end
  end

  // Per-channel slot: a serve and a new event in the same cycle refill the
  // slot; an event into a slot that is not being served is lost.
  for (genvar gi = 0; gi < pCHANNELS; gi++) begin : g_slot
    assign fill[gi]   = I_event[gi] & I_chan_enable[gi] & armed_reg & I_capture_enable;
    assign served[gi] = serve & (grant_idx == pCH_WIDTH'(gi));
    assign drop[gi]   = fill[gi] & pending_reg[gi] & ~served[gi];
    assign pending_next[gi] = I_arm ? 1'b0 :
                              fill[gi] ? 1'b1 :
                              served[gi] ? 1'b0 : pending_reg[gi];
    assign cmd_next[gi] = (fill[gi] & ~drop[gi]) ?
                          I_data_cmd[gi*pCMD_WIDTH +: pCMD_WIDTH] : cmd_reg[gi];
  end

  // Record FSM: the state names the record type written at the edge that
  // entered it, so each transition into TIME/DATA is one FIFO write.
  always_comb begin
    state_next    = ST_IDLE;
    wr_next       = 1'b0;
    serve         = 1'b0;
    out_cmd_next  = '0;
    out_ch_next   = '0;
    out_time_next = '0;
    if (capture_allowed && !I_arm) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            if (ctr_reg > I_max_short_timestamp && !I_timestamps_disable) begin
              state_next    = ST_TIME;
              wr_next       = 1'b1;
              out_cmd_next  = TIME_CMD;
              out_time_next = ctr_reg;
            end else begin
              state_next    = ST_DATA;
              wr_next       = 1'b1;
              serve         = 1'b1;
              out_cmd_next  = cmd_reg[grant_idx];
              out_ch_next   = grant_idx;
              out_time_next = ctr_reg;
            end
          end else if (ctr_reg == TS_MAX && !I_timestamps_disable) begin
            // Keep-alive so the consumer never loses track of elapsed time.
            state_next    = ST_TIME;
            wr_next       = 1'b1;
            out_cmd_next  = TIME_CMD;
            out_time_next = ctr_reg;
          end
        end
        ST_TIME, ST_DATA: begin
          if (grant_valid) begin
            state_next    = ST_DATA;
            wr_next       = 1'b1;
            serve         = 1'b1;
            out_cmd_next  = cmd_reg[grant_idx];
            out_ch_next   = grant_idx;
            // The preceding TIME record already carried the delta.
            out_time_next = (state_reg == ST_TIME) ? '0 : ctr_reg;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    if (I_timestamps_disable) out_time_next = '0;
  end

  always_comb begin
    armed_next = armed_reg;
    if (I_arm) armed_next = 1'b1;
    else if (I_capture_len != '0 && count_reg >= I_capture_len) armed_next = 1'b0;

    count_next = count_reg;
    if (I_arm) count_next = '0;
    else if ((I_count_writes ? wr_next : (armed_reg & I_capture_enable)) && count_reg != '1)
      count_next = count_reg + 1'b1;

    ctr_next = ctr_reg;
    if (I_arm || !armed_reg) ctr_next = '0;
    else if (wr_next) ctr_next = pTS_WIDTH'(1);
    else if (I_capture_enable && ctr_reg != TS_MAX) ctr_next = ctr_reg + 1'b1;

    rr_ptr_next = rr_ptr_reg;
    if (I_arm) rr_ptr_next = '0;
    else if (serve)
      rr_ptr_next = (grant_idx == pCH_WIDTH'(pCHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    drop_sum     = {1'b0, dropped_reg} + 17'($countones(drop));
    dropped_next = I_arm ? 16'h0 : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      armed_reg     <= 1'b0;
      count_reg     <= '0;
      dropped_reg   <= '0;
      pending_reg   <= '0;
      cmd_reg       <= '0;
      rr_ptr_reg    <= '0;
      ctr_reg       <= '0;
      wr_reg        <= 1'b0;
      out_cmd_reg   <= '0;
      out_ch_reg    <= '0;
      out_time_reg  <= '0;
      capturing_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      armed_reg     <= armed_next;
      count_reg     <= count_next;
      dropped_reg   <= dropped_next;
      pending_reg   <= pending_next;
      cmd_reg       <= cmd_next;
      rr_ptr_reg    <= rr_ptr_next;
      ctr_reg       <= ctr_next;
      wr_reg        <= wr_next;
      out_cmd_reg   <= out_cmd_next;
      out_ch_reg    <= out_ch_next;
      out_time_reg  <= out_time_next;
      capturing_reg <= capture_allowed;
    end
  end

  assign fifo.fifo_wr      = wr_reg;
  assign fifo.fifo_command = out_cmd_reg;
  assign fifo.fifo_channel = out_ch_reg;
  assign fifo.fifo_time    = out_time_reg;
  assign O_capturing       = capturing_reg;
  assign O_capture_done    = ~armed_reg;
  assign O_dropped_count   = dropped_reg;
  assign O_pending         = pending_reg;
endmodule

// File: tb/tb_fe_capture_multi.sv
module tb_fe_capture_multi;
  localparam int CH = 4, CW = 2, TW = 16, LW = 24, KTW = 8;
  localparam logic [1:0] CMD_TIME = 2'b11;

  logic fe_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 fe_clk = ~fe_clk;

  logic [CH-1:0]    ev, chen;
  logic [CH*CW-1:0] cmds;
  logic             arm, cen, cw, tsd;
  logic [LW-1:0]    clen;
  logic [TW-1:0]    maxs;
  logic [KTW-1:0]   ka_maxs;
  logic             capt, done, ka_capt, ka_done;
  logic [15:0]      drop, ka_drop;
  logic [CH-1:0]    pend, ka_pend;

  fe_capture_multi_if #(.pCMD_WIDTH(CW), .pCH_WIDTH(2), .pTS_WIDTH(TW))  fif ();
  fe_capture_multi_if #(.pCMD_WIDTH(CW), .pCH_WIDTH(2), .pTS_WIDTH(KTW)) kif ();

  fe_capture_multi #(.pCHANNELS(CH), .pCMD_WIDTH(CW), .pTS_WIDTH(TW), .pLEN_WIDTH(LW)) dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_event(ev), .I_data_cmd(cmds),
    .I_chan_enable(chen), .I_arm(arm), .I_capture_enable(cen), .I_capture_len(clen),
    .I_count_writes(cw), .I_max_short_timestamp(maxs), .I_timestamps_disable(tsd),
    .fifo(fif), .O_capturing(capt), .O_capture_done(done),
    .O_dropped_count(drop), .O_pending(pend)
  );

  fe_capture_multi #(.pCHANNELS(CH), .pCMD_WIDTH(CW), .pTS_WIDTH(KTW), .pLEN_WIDTH(LW)) u_ka (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_event(ev), .I_data_cmd(cmds),
    .I_chan_enable(chen), .I_arm(arm), .I_capture_enable(cen), .I_capture_len(clen),
    .I_count_writes(cw), .I_max_short_timestamp(ka_maxs), .I_timestamps_disable(tsd),
    .fifo(kif), .O_capturing(ka_capt), .O_capture_done(ka_done),
    .O_dropped_count(ka_drop), .O_pending(ka_pend)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int nwr, kn, nmain;
  int ka_at [2];
  logic [15:0] ka_time [2];
  logic [1:0]  ka_cmd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] c, input logic [1:0] ch,
                         input logic [15:0] t);
    chk({tag, "_wr"}, 32'(fif.fifo_wr), 32'd1);
    chk({tag, "_cmd"}, 32'(fif.fifo_command), 32'(c));
    chk({tag, "_ch"}, 32'(fif.fifo_channel), 32'(ch));
    chk({tag, "_time"}, 32'(fif.fifo_time), 32'(t));
    $display("record %s: cmd=%0d ch=%0d time=%0d", tag, fif.fifo_command,
             fif.fifo_channel, fif.fifo_time);
  endtask

  initial begin
    ev = '0; chen = 4'hF; cmds = {2'd3, 2'd2, 2'd1, 2'd0};
    arm = 0; cen = 1; cw = 1; tsd = 0; clen = '0; maxs = 16'd1000; ka_maxs = 8'd200;
    fif.fifo_full = 0; fif.fifo_overflow_blocked = 0;
    kif.fifo_full = 0; kif.fifo_overflow_blocked = 0;

    // Reset state
    #12;
    chk("rst_wr", 32'(fif.fifo_wr), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_capt", 32'(capt), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    @(negedge fe_clk) reset_n = 1;
    step();

    // Simultaneous events on all channels, 4 idle cycles after arm
    arm = 1; step(); arm = 0;
    chk("arm_done", 32'(done), 32'd0);
    repeat (4) step();
    ev = 4'hF; step(); ev = '0;
    chk("sim_pend", 32'(pend), 32'hF);
    chk("sim_nowr", 32'(fif.fifo_wr), 32'd0);
    step(); chk_rec("sim0", 2'd0, 2'd0, 16'd5);
    step(); chk_rec("sim1", 2'd1, 2'd1, 16'd1);
    step(); chk_rec("sim2", 2'd2, 2'd2, 16'd1);
    step(); chk_rec("sim3", 2'd3, 2'd3, 16'd1);
    step();
    chk("sim_end_wr", 32'(fif.fifo_wr), 32'd0);
    chk("sim_end_pend", 32'(pend), 32'd0);

    // Back-pressure and drops on channel 2
    fif.fifo_full = 1; step();
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      ev = 4'b0100; step(); if (fif.fifo_wr) nwr++;
      ev = '0;      step(); if (fif.fifo_wr) nwr++;
    end
    chk("full_nowr", 32'(nwr), 32'd0);
    chk("full_drop", 32'(drop), 32'd2);
    chk("full_pend", 32'(pend), 32'b0100);
    fif.fifo_full = 0;
    step();
    chk("rel_wr", 32'(fif.fifo_wr), 32'd1);
    chk("rel_ch", 32'(fif.fifo_channel), 32'd2);
    chk("rel_cmd", 32'(fif.fifo_command), 32'd2);
    $display("record rel: cmd=%0d ch=%0d", fif.fifo_command, fif.fifo_channel);
    step();
    chk("rel_once", 32'(fif.fifo_wr), 32'd0);

    // Asynchronous reset in the middle of a burst
    ev = 4'hF; step(); ev = '0; step();
    chk("burst_wr", 32'(fif.fifo_wr), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("arst_wr", 32'(fif.fifo_wr), 32'd0);
    chk("arst_done", 32'(done), 32'd1);
    chk("arst_pend", 32'(pend), 32'd0);
    chk("arst_drop", 32'(drop), 32'd0);
    @(negedge fe_clk) reset_n = 1;
    step();

    // Long gap: TIME then DATA with zero time
    maxs = 16'd10;
    cmds = {2'd3, 2'd2, 2'd2, 2'd0};
    arm = 1; step(); arm = 0;
    repeat (499) step();
    ev = 4'b0010; step(); ev = '0;
    step(); chk_rec("gap_time", CMD_TIME, 2'd0, 16'd500);
    step(); chk_rec("gap_data", 2'd2, 2'd1, 16'd0);
    step(); chk("gap_end", 32'(fif.fifo_wr), 32'd0);

    // Same gap with timestamps disabled: DATA only
    tsd = 1;
    arm = 1; step(); arm = 0;
    repeat (499) step();
    ev = 4'b0010; step(); ev = '0;
    step(); chk_rec("nots_data", 2'd2, 2'd1, 16'd0);
    step(); chk("nots_end", 32'(fif.fifo_wr), 32'd0);
    tsd = 0;
    cmds = {2'd3, 2'd2, 2'd1, 2'd0};

    // Length limit of 3 writes, 5 events
    maxs = 16'd1000; clen = 24'd3; cw = 1;
    arm = 1; step(); arm = 0; step();
    chk("len_capt_on", 32'(capt), 32'd1);
    nwr = 0;
    ev = 4'hF; step(); ev = '0; if (fif.fifo_wr) nwr++;
    repeat (8) begin step(); if (fif.fifo_wr) nwr++; end
    ev = 4'b0010; step(); ev = '0; if (fif.fifo_wr) nwr++;
    repeat (5) begin step(); if (fif.fifo_wr) nwr++; end
    chk("len_records", 32'(nwr), 32'd3);
    chk("len_done", 32'(done), 32'd1);
    chk("len_capt_off", 32'(capt), 32'd0);
    chk("len_pend", 32'(pend), 32'b1000);
    arm = 1; step(); arm = 0;
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_pend", 32'(pend), 32'd0);
    nwr = 0;
    ev = 4'b0001; step(); ev = '0;
    repeat (4) begin step(); if (fif.fifo_wr) nwr++; end
    chk("rearm_records", 32'(nwr), 32'd1);
    clen = '0;

    // Keep-alive on the 8-bit timestamp instance
    arm = 1; step(); arm = 0;
    kn = 0; nmain = 0;
    for (int i = 1; i <= 520; i++) begin
      step();
      if (fif.fifo_wr) nmain++;
      if (kif.fifo_wr) begin
        if (kn < 2) begin
          ka_at[kn] = i; ka_time[kn] = 16'(kif.fifo_time); ka_cmd[kn] = kif.fifo_command;
        end
        $display("record keepalive: cycle=%0d cmd=%0d time=%0d", i, kif.fifo_command, kif.fifo_time);
        kn++;
      end
    end
    chk("ka_count", 32'(kn), 32'd2);
    chk("ka_main_quiet", 32'(nmain), 32'd0);
    if (kn >= 2) begin
      chk("ka_at0", 32'(ka_at[0]), 32'd256);
      chk("ka_at1", 32'(ka_at[1]), 32'd511);
      chk("ka_time0", 32'(ka_time[0]), 32'd255);
      chk("ka_time1", 32'(ka_time[1]), 32'd255);
      chk("ka_cmd0", 32'(ka_cmd[0]), 32'(CMD_TIME));
    end

    // Events on a disabled channel are ignored entirely
    chen = 4'b1110; nwr = 0;
    for (int i = 0; i < 2; i++) begin
      ev = 4'b0001; step(); if (fif.fifo_wr) nwr++;
      ev = '0;      step(); if (fif.fifo_wr) nwr++;
    end
    chk("dis_pend", 32'(pend), 32'd0);
    chk("dis_drop", 32'(drop), 32'd0);
    chk("dis_nowr", 32'(nwr), 32'd0);
    chen = 4'hF;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fe_capture_multi.md
# fe_capture_multi

Parametrised multi-channel successor to the single-channel front-end capture controller. It accepts up to pCHANNELS independent event strobes, each with a command code. Each event is held in a one-deep per-channel slot, and slots are served round-robin into one FIFO write stream of records tagged with channel, command and time. It sits between the protocol front ends and the capture FIFO in the fe_clk domain, and adds drop accounting and per-channel enables.

## Interface
- pCHANNELS, 4: number of event channels (2..16); pCH_WIDTH = clog2(pCHANNELS) is derived locally.
- pCMD_WIDTH, 2: width of the per-channel command code.
- pTS_WIDTH, 16: timestamp counter and time-field width.
- pLEN_WIDTH, 24: capture length counter width.
- fe_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_event  in  pCHANNELS  per-channel single-cycle event strobe.
- I_data_cmd  in  pCHANNELS*pCMD_WIDTH  per-channel command; channel k uses bits [k*pCMD_WIDTH +: pCMD_WIDTH].
- I_chan_enable  in  pCHANNELS  channel mask; events on disabled channels are ignored.
- I_arm  in  1  synchronous arm pulse.
- I_capture_enable  in  1  trigger gate.
- I_capture_len  in  pLEN_WIDTH  capture limit; 0 = unlimited.
- I_count_writes  in  1  1 = count FIFO writes; 0 = count armed, enabled cycles.
- I_max_short_timestamp  in  pTS_WIDTH  largest delta carried inline in a DATA record.
- I_timestamps_disable  in  1  suppresses all TIME records and zeroes the time field.
- I_fifo_full, I_fifo_overflow_blocked  in  1  FIFO back-pressure.
- O_fifo_wr  out  1  record strobe.
- O_fifo_command  out  pCMD_WIDTH  channel command, or `FE_FIFO_CMD_TIME.
- O_fifo_channel  out  pCH_WIDTH  source channel; 0 for TIME records.
- O_fifo_time  out  pTS_WIDTH  time field.
- O_capturing  out  1  capture_allowed.
- O_capture_done  out  1  ~armed.
- O_dropped_count  out  16  saturating count of lost events.
- O_pending  out  pCHANNELS  occupied slots.

## Operation
- **Reset** clears all registers; every output is 0, except O_capture_done, which is 1.
- **armed**
  - Set by I_arm.
  - Cleared when capture_count reaches a nonzero I_capture_len.
- **I_arm** also clears capture_count, O_dropped_count, all pending slots, the RR pointer and the timestamp counter.
- **capture_allowed** = armed & I_capture_enable & !I_fifo_full & !I_fifo_overflow_blocked & (capture_count < I_capture_len | I_capture_len == 0).
- **Slot k fill:** the slot is filled (pending bit plus the latched command) when all of the following hold: I_event[k], I_chan_enable[k], armed and I_capture_enable.
- **Event into an occupied slot:** the event is dropped and O_dropped_count is incremented. The counter saturates at 0xFFFF.
- **Slot served and new event in the same cycle:** the slot is refilled with the new command and no drop is counted.
- **Round-robin arbitration:** the grant goes to the lowest pending channel index above the last granted index, wrapping to 0.
- **Blocking:** arbitration stalls while !capture_allowed. Slots hold their contents.
- **Timestamp counter**
  - Increments each cycle while armed & I_capture_enable, saturating at all-ones.
  - Loads 1 in the cycle after any record write.
  - Held at 0 while not armed.
- **FSM states:** IDLE, TIME, DATA.
  - IDLE → DATA when a grant exists and (ctr <= I_max_short_timestamp or timestamps disabled).
  - IDLE → TIME when a grant exists and ctr exceeds the threshold.
  - IDLE → TIME when ctr == all-ones, no slot is pending, capture_allowed holds and timestamps are enabled (keep-alive record).
  - TIME → DATA if the grant is still valid; otherwise TIME → IDLE.
  - DATA → DATA when another grant exists (each DATA state consumes exactly one slot); otherwise DATA → IDLE.
  - Any state → IDLE when capture_allowed deasserts. No record is written in that cycle.
- **Record contents**
  - TIME record: command = `FE_FIFO_CMD_TIME, channel = 0, time = ctr.
  - DATA record after a TIME record: time = 0.
  - Other DATA records: time = ctr.
  - Time field is 0 when I_timestamps_disable is set.
- **capture_count**
  - With I_count_writes = 1, counts O_fifo_wr.
  - With I_count_writes = 0, counts cycles with armed & I_capture_enable.

## Timing
- **Outputs:** all outputs are registered. O_fifo_* change only on fe_clk edges.
- **Event latency:** an event sampled at edge t sets its slot at edge t. The record appears with O_fifo_wr high in the cycle after edge t+1 (2-cycle latency) when short. When long, TIME appears at t+2 and DATA at t+3.
- **Throughput:** one record per cycle sustained; N simultaneous events emit N consecutive DATA records.
- **Back-pressure:** O_fifo_wr is never high in a cycle following an edge at which capture_allowed was 0.
- **Reset:** asynchronous assertion mid-record forces O_fifo_wr to 0 immediately. Release is sampled on the next fe_clk edge.

## Test plan
- **Reset:** assert reset_n low mid-burst → O_fifo_wr = 0 immediately, O_capture_done = 1, O_pending = 0, O_dropped_count = 0.
- **Simultaneous events:** pCHANNELS = 4; arm, then channels 0–3 fire in the same cycle with cmd = k → four DATA records in consecutive cycles, channels 0, 1, 2, 3, first time = ctr value, remaining times = 1.
- **Round robin and drops:** hold I_fifo_full = 1, then pulse channel 2 three times → one slot held, O_dropped_count = 2. Release full → one DATA record on channel 2.
- **Long gap:** I_max_short_timestamp = 10, event after 500 idle cycles → TIME record with time ≈ 500, followed by DATA with time = 0. Repeat with I_timestamps_disable = 1 → DATA only, time = 0.
- **Length limit:** I_capture_len = 3, I_count_writes = 1, 5 events → exactly 3 records, then O_capture_done = 1 and O_capturing = 0. Re-arm → count cleared, capture resumes.
- **Keep-alive:** pTS_WIDTH = 8, no events for 300 cycles → TIME records with time = 255 every 255 cycles. Disabled channel events → no slot, no drop counted.
